mem_access_unit: RTL

Load/store unit between the MIPS datapath and the data-memory port. Consumes the decoded `memop_struct` (type, width, sign) plus effective address and store data, and drives a word-wide, byte-enabled request/acknowledge data-memory interface. Returns load data lane-extracted and sign- or zero-extended, or a store-completion response. Sits in the MEM stage and stalls it via a valid/ready handshake.

---
 rtl/mem_access_unit_pkg.sv | 46 ++++
 rtl/mem_lane_fmt.sv | 47 ++++
 rtl/mem_access_unit.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared load/store types for the MEM stage: decoded memop fields, bus word
// types, the load/store unit state encoding and its default timeout.
package mem_access_unit_pkg;

  typedef logic [31:0] dm_addr_t;
  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'b00,
    MEM_LOAD  = 2'b01,
    MEM_STORE = 2'b10,
    MEM_RSVD  = 2'b11
  } ls_type_enum;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10,
    MEM_WBAD = 2'b11
  } ls_width_enum;

  typedef struct packed {
    ls_type_enum  ls_type;
    ls_width_enum ls_width;
    logic         sign;
  } memop_struct;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } mau_state_enum;

  localparam int unsigned MAU_TIMEOUT_CYCLES = 16;

  // True for an illegal width or an address not aligned to the access size.
  function automatic logic mau_illegal(input ls_width_enum w, input logic [1:0] off);
    case (w)
      MEM_BYTE: return 1'b0;
      MEM_HALF: return off[0];
      MEM_WORD: return off != 2'b00;
      default:  return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// Little-endian lane formatter (combinational).
//   width/sign/off : access size, load sign flag, byte offset addr[1:0]
//   st_data        : store source value  -> be_c, st_data_c (lane-replicated)
//   ld_word        : memory read word    -> ld_data_c (lane-selected, extended)
module mem_lane_fmt
  import mem_access_unit_pkg::*;
(
  input  ls_width_enum width,
  input  logic         sign,
  input  logic [1:0]   off,
  input  word_t        st_data,
  input  word_t        ld_word,
  output logic [3:0]   be_c,
  output word_t        st_data_c,
  output word_t        ld_data_c
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    be_c      = 4'b0000;
    st_data_c = '0;
    ld_data_c = '0;
    ld_byte   = ld_word[{off, 3'b000} +: 8];
    ld_half   = off[1] ? ld_word[31:16] : ld_word[15:0];
    case (width)
      MEM_BYTE: begin
        be_c      = 4'b0001 << off;
        st_data_c = {4{st_data[7:0]}};
        ld_data_c = {{24{sign & ld_byte[7]}}, ld_byte};
      end
      MEM_HALF: begin
        be_c      = off[1] ? 4'b1100 : 4'b0011;
        st_data_c = {2{st_data[15:0]}};
        ld_data_c = {{16{sign & ld_half[15]}}, ld_half};
      end
      MEM_WORD: begin
        be_c      = 4'b1111;
        st_data_c = st_data;
        ld_data_c = ld_word;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: accepts one memop via req_valid/req_ready, runs a
// byte-enabled dm_req/dm_ack access, returns formatted load data or a store
// completion via resp_valid/resp_ready. Misaligned/illegal ops return addr_err
// without touching memory.
// Ports: clk, rst_n; req_valid/req_ready, memop, addr, wdata; resp_valid/
// resp_ready, rdata, addr_err, bus_err; dm_req, dm_we, dm_be, dm_addr,
// dm_wdata, dm_ack, dm_rdata.
// Build option: MAU_TIMEOUT_EN enables the dm_ack timeout (TIMEOUT_CYCLES),
// reported as bus_err; otherwise bus_err is always 0.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = MAU_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  memop_struct memop,
  input  dm_addr_t    addr,
  input  word_t       wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output word_t       rdata,
  output logic        addr_err,
  output logic        bus_err,
  output logic        dm_req,
  output logic        dm_we,
  output logic [3:0]  dm_be,
  output dm_addr_t    dm_addr,
  output word_t       dm_wdata,
  input  logic        dm_ack,
  input  word_t       dm_rdata
);

  mau_state_enum state_q, state_d;
  memop_struct   op_q, op_d;
  logic [1:0]    off_q, off_d;
  logic          resp_valid_d, addr_err_d, bus_err_d;
  logic          dm_req_d, dm_we_d;
  logic [3:0]    dm_be_d;
  word_t         rdata_d, dm_wdata_d;
  dm_addr_t      dm_addr_d;

  ls_width_enum  fmt_width;
  logic          fmt_sign;
  logic [1:0]    fmt_off;
  logic [3:0]    fmt_be;
  word_t         fmt_st, fmt_ld;

`ifdef MAU_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`else
  logic unused_timeout_param;
  assign unused_timeout_param = ^32'(TIMEOUT_CYCLES);
`endif

  assign req_ready = (state_q == ST_IDLE);

  // Formatter sees the incoming op while idle (store lanes), the latched op otherwise (load lanes).
  assign fmt_width = (state_q == ST_IDLE) ? memop.ls_width : op_q.ls_width;
  assign fmt_sign  = (state_q == ST_IDLE) ? memop.sign     : op_q.sign;
  assign fmt_off   = (state_q == ST_IDLE) ? addr[1:0]      : off_q;

  mem_lane_fmt u_fmt (
    .width     (fmt_width),
    .sign      (fmt_sign),
    .off       (fmt_off),
    .st_data   (wdata),
    .ld_word   (dm_rdata),
    .be_c      (fmt_be),
    .st_data_c (fmt_st),
    .ld_data_c (fmt_ld)
  );

  // Next-state and next-output decode.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    off_d        = off_q;
    resp_valid_d = resp_valid;
    rdata_d      = rdata;
    addr_err_d   = addr_err;
    bus_err_d    = bus_err;
    dm_req_d     = dm_req;
    dm_we_d      = dm_we;
    dm_be_d      = dm_be;
    dm_addr_d    = dm_addr;
    dm_wdata_d   = dm_wdata;
`ifdef MAU_TIMEOUT_EN
    cnt_d        = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_d  = memop;
          off_d = addr[1:0];
          if (memop.ls_type != MEM_NONE && mau_illegal(memop.ls_width, addr[1:0])) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            addr_err_d   = 1'b1;
            rdata_d      = '0;
          end else if (memop.ls_type == MEM_NONE || memop.ls_type == MEM_RSVD) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            rdata_d      = '0;
          end else begin
            state_d    = ST_ACCESS;
            dm_req_d   = 1'b1;
            dm_we_d    = (memop.ls_type == MEM_STORE);
            dm_be_d    = fmt_be;
            dm_addr_d  = {addr[31:2], 2'b00};
            dm_wdata_d = (memop.ls_type == MEM_STORE) ? fmt_st : '0;
`ifdef MAU_TIMEOUT_EN
            cnt_d      = '0;
`endif
          end
        end
      end
      ST_ACCESS: begin
        // An ack on the final counted cycle still completes normally.
        if (dm_ack) begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          rdata_d      = (op_q.ls_type == MEM_LOAD) ? fmt_ld : '0;
          dm_req_d     = 1'b0;
          dm_we_d      = 1'b0;
          dm_be_d      = '0;
          dm_addr_d    = '0;
          dm_wdata_d   = '0;
        end
`ifdef MAU_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          bus_err_d    = 1'b1;
          rdata_d      = '0;
          dm_req_d     = 1'b0;
          dm_we_d      = 1'b0;
          dm_be_d      = '0;
          dm_addr_d    = '0;
          dm_wdata_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d      = ST_IDLE;
          resp_valid_d = 1'b0;
          rdata_d      = '0;
          addr_err_d   = 1'b0;
          bus_err_d    = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      off_q      <= '0;
      resp_valid <= 1'b0;
      rdata      <= '0;
      addr_err   <= 1'b0;
      bus_err    <= 1'b0;
      dm_req     <= 1'b0;
      dm_we      <= 1'b0;
      dm_be      <= '0;
      dm_addr    <= '0;
      dm_wdata   <= '0;
`ifdef MAU_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      off_q      <= off_d;
      resp_valid <= resp_valid_d;
      rdata      <= rdata_d;
      addr_err   <= addr_err_d;
      bus_err    <= bus_err_d;
      dm_req     <= dm_req_d;
      dm_we      <= dm_we_d;
      dm_be      <= dm_be_d;
      dm_addr    <= dm_addr_d;
      dm_wdata   <= dm_wdata_d;
`ifdef MAU_TIMEOUT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

endmodule
